feature_line_buffer: RTL
========================

Name: feature_line_buffer

Overview:
- Parametrised successor to the feature row cache.
- Takes a row-major feature stream of one pixel per beat. Each pixel is DATA_W bits, covering all channels of one spatial position.
- Emits, per accepted pixel, a vertical column of KERNEL_H pixels drawn from the current and previous KERNEL_H-1 rows, for the conv window assembler.
- Adds over the previous generation: generic kernel height, valid/ready backpressure on both sides, run-time column count, and a top zero-padding mode.

Parameters:
- DATA_W, 256, bits per pixel (all channels).
- KERNEL_H, 3, rows per output column; legal range 2..7.
- MAX_COL, 1024, maximum row length in pixels; line storage depth.
- COL_W, 10, width of col_size; must satisfy 2^COL_W >= MAX_COL.

Ports:
- system_clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- rebuild_structure, input, 1, synchronous restart pulse; latches col_size and pad_mode.
- col_size, input, COL_W, pixels per row.
- pad_mode, input, 1, 0 = VALID (no padding), 1 = TOP_PAD.
- in_data, input, DATA_W, incoming pixel.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, buffer can accept this cycle.
- out_data, output, KERNEL_H*DATA_W, column; LSB slice = current row, slice k = row r-k.
- out_valid, output, 1, out_data valid.
- out_ready, output-consumer input, 1, consumer accepts this cycle.
- out_col, output, COL_W, column index of out_data.
- out_last_col, output, 1, out_col equals latched col_size-1.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_col=0, out_last_col=0. Counters col_cnt=0 and row_fill=0. Latched col_size = MAX_COL, pad_mode = 0. in_ready goes to 1 after reset release. Line storage is not cleared.
- Accept rule: input beat accepted when in_valid & in_ready. in_ready = ~out_valid | out_ready, a single output stage with no combinational in_valid→out_valid path.
- Latency: an accepted beat at edge t appears on out_data at t+1 when it is emitted.
- Output hold: out_data, out_col and out_last_col hold stable while out_valid & ~out_ready.
- Storage: KERNEL_H-1 line memories, each MAX_COL x DATA_W. On accept at column c:
  - output slice 0 = in_data, slice k = line[k-1][c];
  - then line[0][c] <= in_data and line[k][c] <= line[k-1][c] (cascade).
- Counters:
  - col_cnt increments per accepted beat and wraps to 0 after latched_col-1.
  - On wrap, row_fill increments and saturates at KERNEL_H-1.
- VALID mode: an accepted beat sets out_valid only if row_fill == KERNEL_H-1. Otherwise the beat is stored, not emitted.
- TOP_PAD mode: every accepted beat is emitted. Slices k > row_fill are forced to zero.
- rebuild_structure=1: col_cnt=0, row_fill=0, out_valid=0 next cycle. col_size and pad_mode are latched. Any input beat in the same cycle is dropped, and in_ready=0 that cycle.
- col_size latching: a value of 0 latches as 1; a value > MAX_COL latches as MAX_COL.
- Mid-row rebuild: discards the partial row. Stale line contents are never emitted because of row_fill masking.
- Bubbles: in_valid gaps leave all state unchanged.
- Simultaneous accept-out and accept-in: full throughput of 1 beat/cycle.
- Async reset mid-row: all state returns to reset values. The next row starts fresh.

Decomposition:
- Shared package (the team parameters file) defines: DATA_W / COL_W defaults, PAD_VALID=0, PAD_TOP=1, KERNEL_H limits.
- Natural sub-module: line_buffer_ram, a single-port-style MAX_COL x DATA_W read-before-write memory, instantiated KERNEL_H-1 times via generate.
- Counters, masking and the output register stay in the top.

Test Plan:
- Test configuration: KERNEL_H=3, DATA_W=16. Rebuild with col_size=18, VALID mode. Stream 1..18 repeatedly with out_ready=1.
  - First out_valid occurs on the 37th accepted beat.
  - out_data = {1,1,1} (slices 2,1,0), out_col=0.
  - At col 17, out_last_col=1 with data {18,18,18}.
- TOP_PAD, col_size=4, stream 1..4 per row. Row 0 outputs {0,0,p}; row 1 outputs {0,p,p}; row 2 outputs {p,p,p}. Every beat is emitted.
- Backpressure: hold out_ready=0 for 5 cycles mid-row.
  - in_ready drops the cycle after out_valid rises.
  - out_data is stable throughout.
  - No beat is lost or duplicated; check the out_col sequence is continuous.
- Input bubbles: in_valid low for 20 cycles at col 9 of row 2 (in_valid=0 throughout). The next output resumes at out_col=9 with correct rows.
- Rebuild at col 7 of row 3 with col_size=0.
  - out_valid=0 next cycle.
  - Latched size becomes 1.
  - VALID mode emits on the 3rd accepted beat after rebuild.
- Async reset asserted while out_valid=1 and out_ready=0: all outputs go to 0 immediately. in_ready=1 after release.

Source files
------------

// File: rtl/feature_line_buffer_pkg.sv
// feature_line_buffer_pkg: shared defaults and encodings for the feature line buffer
package feature_line_buffer_pkg;
  localparam int DATA_W_DEF = 256;
  localparam int COL_W_DEF = 10;
  localparam int MAX_COL_DEF = 1024;
  localparam int KERNEL_H_MIN = 2;
  localparam int KERNEL_H_MAX = 7;
  localparam logic PAD_VALID = 1'b0;
  localparam logic PAD_TOP = 1'b1;
endpackage

// File: rtl/feature_line_buffer_ram.sv
// feature_line_buffer_ram: DEPTH x DATA_W line memory, old word readable while the new one is written
module feature_line_buffer_ram
  import feature_line_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = MAX_COL_DEF,
  parameter int ADDR_W = COL_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/feature_line_buffer.sv
// feature_line_buffer: row-major pixel stream in, KERNEL_H-tall pixel columns out with optional top zero padding
module feature_line_buffer
  import feature_line_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KERNEL_H = 3,
  parameter int MAX_COL = MAX_COL_DEF,
  parameter int COL_W = COL_W_DEF
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       rebuild_structure,
  input  logic [COL_W-1:0]           col_size,
  input  logic                       pad_mode,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [KERNEL_H*DATA_W-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COL_W-1:0]           out_col,
  output logic                       out_last_col
);
  localparam logic [2:0] FULL = 3'(KERNEL_H - 1);
  localparam logic [COL_W:0] MAX_C = (COL_W+1)'(MAX_COL);
  if (KERNEL_H < KERNEL_H_MIN || KERNEL_H > KERNEL_H_MAX) begin : g_bad_kh
    $error("KERNEL_H out of range");
  end
  logic [COL_W-1:0] col_cnt, col_last, size_last;
  logic [2:0] row_fill;
  logic pad_lat, accept, emit, wrap;
  logic [DATA_W-1:0] rd [KERNEL_H-1];
  logic [DATA_W-1:0] wr [KERNEL_H-1];
  logic [KERNEL_H*DATA_W-1:0] col_bus;
  assign in_ready = (~out_valid | out_ready) & ~rebuild_structure;
  assign accept = in_valid & in_ready;
  assign wrap = col_cnt == col_last;
  assign emit = (pad_lat == PAD_TOP) | (row_fill == FULL);
  assign size_last = col_size == '0 ? '0 : ({1'b0, col_size} > MAX_C) ? COL_W'(MAX_COL - 1) : col_size - 1'b1;
  assign col_bus[DATA_W-1:0] = in_data;
  for (genvar j = 0; j < KERNEL_H - 1; j++) begin : g_line
    if (j == 0) begin : g_head
      assign wr[j] = in_data;
    end else begin : g_tail
      assign wr[j] = rd[j-1];
    end
    feature_line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(MAX_COL), .ADDR_W(COL_W)) u_ram (
      .clk(system_clk), .we(accept), .addr(col_cnt), .wdata(wr[j]), .rdata(rd[j])
    );
    assign col_bus[(j+1)*DATA_W +: DATA_W] = 3'(j + 1) > row_fill ? '0 : rd[j];
  end
  always_ff @(posedge system_clk or negedge rst_n)
    if (!rst_n) begin
      col_cnt <= '0;
      row_fill <= '0;
      col_last <= COL_W'(MAX_COL - 1);
      pad_lat <= PAD_VALID;
      out_valid <= 1'b0;
      out_data <= '0;
      out_col <= '0;
      out_last_col <= 1'b0;
    end else if (rebuild_structure) begin
      col_cnt <= '0;
      row_fill <= '0;
      col_last <= size_last;
      pad_lat <= pad_mode;
      out_valid <= 1'b0;
    end else if (accept) begin
      col_cnt <= wrap ? '0 : col_cnt + 1'b1;
      if (wrap && row_fill != FULL) row_fill <= row_fill + 1'b1;
      out_valid <= emit;
      if (emit) begin
        out_data <= col_bus;
        out_col <= col_cnt;
        out_last_col <= wrap;
      end
    end else if (out_ready) out_valid <= 1'b0;
endmodule
